pwd_entry_ctrl: RTL and testbench

Password-entry controller that produces the digit, cursor and text-mode inputs consumed by the 4-digit seven-segment display driver. It accepts pre-debounced push-button levels and steps the user through prompt, digit entry and verification. It reports the outcome as OK, Err, timeout or lockout status flags, and emits an unlock pulse for the clock/alarm logic.

---
 rtl/pwd_entry_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pwd_entry_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwd_entry_ctrl.sv
// pwd_entry_ctrl: password-entry sequencer for the 4-digit display.
// Turns debounced button levels into digit/cursor edits, checks the
// entered code against PWD and reports OK / Err / timeout / lockout.
// Handshake: none; buttons are plain levels sampled every clock, and
// tick_1s is a single-cycle strobe, so there is no valid/ready pairing.
module pwd_entry_ctrl #(
    parameter logic [15:0] PWD       = 16'h1234,
    parameter int          TIMEOUT_S = 10,
    parameter int          RESULT_S  = 2,
    parameter int          MAX_TRIES = 3,
    parameter int          LOCK_S    = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1s,
    input  logic       btn_start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [1:0] cursor_pos,
    output logic       edit_active,
    output logic       show_pwd,
    output logic       show_ok,
    output logic       show_err,
    output logic       show_tmo,
    output logic       unlocked,
    output logic       locked,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PROMPT = 3'd1,
        S_ENTRY  = 3'd2,
        S_OK     = 3'd3,
        S_ERR    = 3'd4,
        S_TMO    = 3'd5,
        S_LOCK   = 3'd6
    } state_t;

    // One shared dwell timer, sized for the longest hold.
    localparam int TMAX_A = (TIMEOUT_S > RESULT_S) ? TIMEOUT_S : RESULT_S;
    localparam int TMAX   = (TMAX_A > LOCK_S) ? TMAX_A : LOCK_S;
    localparam int TW     = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_S);
    localparam logic [TW-1:0] RESULT_T  = TW'(RESULT_S);
    localparam logic [TW-1:0] LOCK_T    = TW'(LOCK_S);
    localparam logic [2:0]    MAX_T     = 3'(MAX_TRIES);

    state_t          state_q, state_d;
    logic [3:0]      dig_q [4];
    logic [3:0]      dig_d [4];
    logic [1:0]      cur_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      fail_q, fail_d;
    logic            pulse_d;
    logic [3:0]      prev_q;
    logic [3:0]      btn_now;
    logic [3:0]      btn_edge;
    logic            start_e, up_e, down_e, next_e, any_e;

    // Bit order {start, up, down, next}; prev resets high so a held button
    // does not fire on reset release.
    assign btn_now  = {btn_start, btn_up, btn_down, btn_next};
    assign btn_edge = btn_now & ~prev_q;
    assign start_e  = btn_edge[3];
    assign up_e     = btn_edge[2];
    assign down_e   = btn_edge[1];
    assign next_e   = btn_edge[0];
    assign any_e    = up_e | down_e | next_e;

    assign d0        = dig_q[0];
    assign d1        = dig_q[1];
    assign d2        = dig_q[2];
    assign d3        = dig_q[3];
    assign fsm_state = state_q;

    // Next-state, digit, cursor, timer and fail-count decisions.
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        cur_d   = cursor_pos;
        timer_d = timer_q;
        fail_d  = fail_q;
        pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_e) begin
                    state_d = S_PROMPT;
                    dig_d   = '{default: 4'd0};
                    cur_d   = 2'd3;
                    timer_d = '0;
                end
            end
            S_PROMPT: begin
                if (timer_q == TIMEOUT_T) begin
                    state_d = S_TMO;
                    timer_d = '0;
                end else if (any_e) begin
                    // The waking edge is swallowed; it never edits a digit.
                    state_d = S_ENTRY;
                    timer_d = '0;
                end else if (tick_1s) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ENTRY: begin
                if (timer_q == TIMEOUT_T) begin
                    state_d = S_TMO;
                    timer_d = '0;
                end else if (any_e) begin
                    // Activity clears the timer even if a tick arrives too.
                    timer_d = '0;
                    if (next_e) begin
                        if (cursor_pos != 2'd0) begin
                            cur_d = cursor_pos - 2'd1;
                        end else if ({dig_q[3], dig_q[2], dig_q[1], dig_q[0]} == PWD) begin
                            state_d = S_OK;
                            fail_d  = 3'd0;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = S_ERR;
                            if (fail_q != 3'd7) fail_d = fail_q + 3'd1;
                        end
                    end else if (up_e) begin
                        dig_d[cursor_pos] = (dig_q[cursor_pos] == 4'd9) ? 4'd0
                                                                        : dig_q[cursor_pos] + 4'd1;
                    end else begin
                        dig_d[cursor_pos] = (dig_q[cursor_pos] == 4'd0) ? 4'd9
                                                                        : dig_q[cursor_pos] - 4'd1;
                    end
                end else if (tick_1s) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_OK, S_TMO: begin
                if (timer_q == RESULT_T) begin
                    state_d = S_IDLE;
                    dig_d   = '{default: 4'd0};
                    cur_d   = 2'd3;
                    timer_d = '0;
                end else if (tick_1s) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ERR: begin
                if (timer_q == RESULT_T) begin
                    state_d = (fail_q >= MAX_T) ? S_LOCK : S_ENTRY;
                    dig_d   = '{default: 4'd0};
                    cur_d   = 2'd3;
                    timer_d = '0;
                end else if (tick_1s) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_LOCK: begin
                if (timer_q == LOCK_T) begin
                    state_d = S_IDLE;
                    fail_d  = 3'd0;
                    dig_d   = '{default: 4'd0};
                    cur_d   = 2'd3;
                    timer_d = '0;
                end else if (tick_1s) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                dig_d   = '{default: 4'd0};
                cur_d   = 2'd3;
                timer_d = '0;
            end
        endcase
    end

    // State, data and output registers; outputs decode the upcoming state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            dig_q       <= '{default: 4'd0};
            cursor_pos  <= 2'd3;
            timer_q     <= '0;
            fail_q      <= 3'd0;
            prev_q      <= 4'b1111;
            edit_active <= 1'b0;
            show_pwd    <= 1'b0;
            show_ok     <= 1'b0;
            show_err    <= 1'b0;
            show_tmo    <= 1'b0;
            unlocked    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dig_q       <= dig_d;
            cursor_pos  <= cur_d;
            timer_q     <= timer_d;
            fail_q      <= fail_d;
            prev_q      <= btn_now;
            edit_active <= (state_d == S_ENTRY);
            show_pwd    <= (state_d == S_PROMPT);
            show_ok     <= (state_d == S_OK);
            show_err    <= (state_d == S_ERR) || (state_d == S_LOCK);
            show_tmo    <= (state_d == S_TMO);
            unlocked    <= pulse_d;
            locked      <= (state_d == S_LOCK);
        end
    end

endmodule

// File: tb/tb_pwd_entry_ctrl.sv
// tb_pwd_entry_ctrl: directed scenarios plus random button/tick traffic,
// every cycle compared against a behavioural model of the entry rules.
module tb_pwd_entry_ctrl;

    localparam logic [15:0] PWD       = 16'h1234;
    localparam int          TIMEOUT_S = 10;
    localparam int          RESULT_S  = 2;
    localparam int          MAX_TRIES = 3;
    localparam int          LOCK_S    = 30;

    // Button masks {start, up, down, next}
    localparam logic [3:0] B_START = 4'b1000;
    localparam logic [3:0] B_UP    = 4'b0100;
    localparam logic [3:0] B_DOWN  = 4'b0010;
    localparam logic [3:0] B_NEXT  = 4'b0001;

    localparam logic [24:0] RESET_VEC = {16'h0000, 2'd3, 7'b0000000};

    // Model modes
    localparam int M_IDLE = 0, M_PROMPT = 1, M_ENTRY = 2, M_OK = 3,
                   M_ERR = 4, M_TMO = 5, M_LOCK = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1s = 1'b0;
    logic       btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_next = 1'b0;
    logic [3:0] d0, d1, d2, d3;
    logic [1:0] cursor_pos;
    logic       edit_active, show_pwd, show_ok, show_err, show_tmo, unlocked, locked;
    logic [2:0] fsm_state;
    logic [24:0] dut_vec;

    int n_cmp = 0;
    int n_err = 0;
    int unl_cnt = 0;
    logic [24:0] exp_q[$];

    // Model state
    int m_mode = M_IDLE;
    int m_dig[4] = '{0, 0, 0, 0};
    int m_cur = 3;
    int m_dwell = 0;
    int m_fails = 0;
    bit m_pulse = 1'b0;
    bit m_prev[4] = '{1'b1, 1'b1, 1'b1, 1'b1};

    pwd_entry_ctrl #(
        .PWD(PWD), .TIMEOUT_S(TIMEOUT_S), .RESULT_S(RESULT_S),
        .MAX_TRIES(MAX_TRIES), .LOCK_S(LOCK_S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s),
        .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .cursor_pos(cursor_pos),
        .edit_active(edit_active), .show_pwd(show_pwd), .show_ok(show_ok),
        .show_err(show_err), .show_tmo(show_tmo), .unlocked(unlocked),
        .locked(locked), .fsm_state(fsm_state)
    );

    assign dut_vec = {d3, d2, d1, d0, cursor_pos, edit_active, show_pwd,
                      show_ok, show_err, show_tmo, unlocked, locked};

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (fsm %0d, t=%0t)", name, got, exp, fsm_state, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pwd_value();
        return int'(PWD[15:12]) * 1000 + int'(PWD[11:8]) * 100 + int'(PWD[7:4]) * 10 + int'(PWD[3:0]);
    endfunction

    function automatic int entered_value();
        return m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
    endfunction

    task automatic m_enter(input int mode);
        m_mode  = mode;
        m_dwell = 0;
    endtask

    task automatic m_blank();
        m_dig = '{0, 0, 0, 0};
        m_cur = 3;
    endtask

    task automatic m_count_tick();
        if (tick_1s) m_dwell++;
    endtask

    task automatic model_step();
        bit e_start, e_up, e_down, e_next;
        if (!reset_n) begin
            m_enter(M_IDLE);
            m_blank();
            m_fails = 0;
            m_pulse = 1'b0;
            m_prev  = '{1'b1, 1'b1, 1'b1, 1'b1};
            return;
        end
        e_start = btn_start && !m_prev[0];
        e_up    = btn_up    && !m_prev[1];
        e_down  = btn_down  && !m_prev[2];
        e_next  = btn_next  && !m_prev[3];
        m_prev  = '{btn_start, btn_up, btn_down, btn_next};
        m_pulse = 1'b0;
        case (m_mode)
            M_IDLE: if (e_start) begin m_enter(M_PROMPT); m_blank(); end
            M_PROMPT: begin
                if (m_dwell == TIMEOUT_S) m_enter(M_TMO);
                else if (e_up || e_down || e_next) m_enter(M_ENTRY);
                else m_count_tick();
            end
            M_ENTRY: begin
                if (m_dwell == TIMEOUT_S) m_enter(M_TMO);
                else if (e_next) begin
                    m_dwell = 0;
                    if (m_cur > 0) m_cur--;
                    else if (entered_value() == pwd_value()) begin
                        m_enter(M_OK); m_fails = 0; m_pulse = 1'b1;
                    end else begin
                        m_enter(M_ERR); m_fails = (m_fails < 7) ? m_fails + 1 : 7;
                    end
                end else if (e_up) begin
                    m_dwell = 0; m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
                end else if (e_down) begin
                    m_dwell = 0; m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
                end else m_count_tick();
            end
            M_OK, M_TMO: begin
                if (m_dwell == RESULT_S) begin m_enter(M_IDLE); m_blank(); end
                else m_count_tick();
            end
            M_ERR: begin
                if (m_dwell == RESULT_S) begin
                    m_blank();
                    m_enter((m_fails >= MAX_TRIES) ? M_LOCK : M_ENTRY);
                end else m_count_tick();
            end
            default: begin
                if (m_dwell == LOCK_S) begin m_fails = 0; m_blank(); m_enter(M_IDLE); end
                else m_count_tick();
            end
        endcase
    endtask

    function automatic logic [24:0] model_vec();
        return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0]), 2'(m_cur),
                m_mode == M_ENTRY, m_mode == M_PROMPT, m_mode == M_OK,
                (m_mode == M_ERR) || (m_mode == M_LOCK), m_mode == M_TMO,
                m_pulse, m_mode == M_LOCK};
    endfunction

    // Scoreboard: model advances on each edge, DUT checked 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            exp_q.push_back(model_vec());
            #1;
            if (unlocked === 1'b1) unl_cnt++;
            check("cycle", 32'(dut_vec), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_btn(input logic [3:0] m);
        {btn_start, btn_up, btn_down, btn_next} = m;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk); set_btn(m);
        @(negedge clk); set_btn(4'b0000);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk); tick_1s = 1'b1;
            @(negedge clk); tick_1s = 1'b0;
        end
    endtask

    task automatic key_digit(input int v);
        repeat (v) press(B_UP);
    endtask

    task automatic enter_code(input int a3, input int a2, input int a1, input int a0);
        key_digit(a3); press(B_NEXT);
        key_digit(a2); press(B_NEXT);
        key_digit(a1); press(B_NEXT);
        key_digit(a0); press(B_NEXT);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int u0;
        idle_cyc(3);
        reset_n = 1'b1;
        idle_cyc(2);
        check("reset_vec", 32'(dut_vec), 32'(RESET_VEC));

        // Start held through reset release must not fire.
        @(negedge clk); reset_n = 1'b0; btn_start = 1'b1;
        idle_cyc(2); reset_n = 1'b1;
        idle_cyc(3);
        check("start_held_no_prompt", 32'(show_pwd), 32'd0);
        btn_start = 1'b0;
        idle_cyc(1);
        press(B_START);
        check("prompt", 32'({show_pwd, edit_active}), 32'b10);

        // Waking edge consumed, then correct code.
        press(B_UP);
        check("entry_consumed", 32'({edit_active, d3, d2, d1, d0}), 32'({1'b1, 16'h0000}));
        u0 = unl_cnt;
        key_digit(1); press(B_NEXT);
        check("cursor_after_next", 32'(cursor_pos), 32'd2);
        key_digit(2); press(B_NEXT);
        key_digit(3); press(B_NEXT);
        key_digit(4);
        check("digits_1234", 32'({d3, d2, d1, d0, cursor_pos}), 32'({16'h1234, 2'd0}));
        press(B_NEXT);
        check("ok_shown", 32'({show_ok, show_err, edit_active}), 32'b100);
        idle_cyc(3);
        check("unlock_one_cycle", 32'(unl_cnt - u0), 32'd1);
        tick(2); idle_cyc(1);
        check("ok_to_idle", 32'(dut_vec), 32'(RESET_VEC));

        // Wrong code 1235.
        press(B_START); press(B_UP);
        enter_code(1, 2, 3, 5);
        check("err_shown", 32'({show_err, show_ok, locked}), 32'b100);
        tick(2); idle_cyc(1);
        check("err_to_entry", 32'({edit_active, show_err, d3, d2, d1, d0, cursor_pos}),
              32'({2'b10, 16'h0000, 2'd3}));

        // Two more failures -> lockout.
        enter_code(0, 0, 0, 0);
        tick(2); idle_cyc(1);
        enter_code(0, 0, 0, 0);
        tick(2); idle_cyc(1);
        check("locked", 32'({locked, show_err, edit_active}), 32'b110);
        press(B_START);
        check("start_ignored_locked", 32'({show_pwd, locked}), 32'b01);
        tick(LOCK_S - 1); idle_cyc(1);
        check("still_locked", 32'(locked), 32'd1);
        tick(1); idle_cyc(1);
        check("lock_release", 32'(dut_vec), 32'(RESET_VEC));

        // Fail count cleared: one failure does not lock.
        press(B_START); press(B_UP);
        enter_code(0, 0, 0, 0);
        tick(2); idle_cyc(1);
        check("fails_cleared", 32'({edit_active, locked}), 32'b10);

        // Inactivity timeout in ENTRY.
        tick(TIMEOUT_S); idle_cyc(1);
        check("timeout", 32'({show_tmo, edit_active}), 32'b10);
        tick(2); idle_cyc(1);
        check("tmo_to_idle", 32'(dut_vec), 32'(RESET_VEC));

        // Edge coinciding with the tenth tick keeps ENTRY.
        press(B_START); press(B_UP);
        tick(TIMEOUT_S - 1);
        @(negedge clk); tick_1s = 1'b1; btn_up = 1'b1;
        @(negedge clk); tick_1s = 1'b0; btn_up = 1'b0;
        idle_cyc(1);
        check("edge_tick_clear", 32'({edit_active, show_tmo, d3}), 32'({2'b10, 4'd1}));
        tick(TIMEOUT_S - 1); idle_cyc(1);
        check("timer_restarted", 32'(edit_active), 32'd1);
        tick(1); idle_cyc(1);
        check("timeout_after_clear", 32'(show_tmo), 32'd1);
        tick(2); idle_cyc(1);

        // Wraps and priority.
        press(B_START); press(B_UP);
        press(B_DOWN);
        check("wrap_down", 32'(d3), 32'd9);
        press(B_UP);
        check("wrap_up", 32'(d3), 32'd0);
        press(B_UP);
        press(B_UP | B_DOWN | B_NEXT);
        check("next_priority", 32'({d3, cursor_pos}), 32'({4'd1, 2'd2}));
        key_digit(2); press(B_NEXT);
        key_digit(3); press(B_NEXT);
        key_digit(4); press(B_NEXT);
        check("ok_again", 32'(show_ok), 32'd1);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("async_reset", 32'(dut_vec), 32'(RESET_VEC));
        idle_cyc(2); reset_n = 1'b1;
        idle_cyc(2);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            btn_start = ($urandom_range(0, 15) == 0);
            btn_up    = ($urandom_range(0, 2) == 0);
            btn_down  = ($urandom_range(0, 3) == 0);
            btn_next  = ($urandom_range(0, 4) == 0);
            tick_1s   = ($urandom_range(0, 3) == 0);
            reset_n   = ($urandom_range(0, 799) != 0);
        end
        @(negedge clk);
        set_btn(4'b0000); tick_1s = 1'b0; reset_n = 1'b1;
        idle_cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
